// File: rtl/vdelay_buf.sv
// ---------------------------------------------------------------------------
// vdelay_buf -- variable-tap delay line built on a circular buffer.
//
// Every enabled clock (ce=1) writes d into a DEPTH-entry ring and advances
// the write pointer. The output y is the word written a+1 enabled shifts ago.
// y is forced to zero, and vld is low, until at least a+1 words have been
// written since the last reset or flush.
//
// Parameters
//   WIDTH : data word width, 1..72
//   DEPTH : ring size / maximum delay, power of two, 2..256
//
// Ports
//   clk  : sole clock, rising edge
//   rst  : synchronous active-high reset; clears wp and fill, not the RAM
//   d    : input word, written when ce=1
//   a    : tap select, delay = a+1 enabled shifts
//   ce   : shift enable
//   clr  : synchronous flush of the fill count; wp and RAM untouched
//   y    : delayed word at tap a, zero when not valid
//   vld  : selected tap holds a word written since last reset/flush
//   fill : words written since last reset/flush, saturating at DEPTH
//
// Build option
//   VDELAY_BUF_OREG_EN : when defined, y and vld are registered on every
//                        clk edge, adding one cycle of latency. fill stays
//                        combinational from its register in both builds.
// ---------------------------------------------------------------------------
module vdelay_buf #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         d,
  input  logic [$clog2(DEPTH)-1:0] a,
  input  logic                     ce,
  input  logic                     clr,
  output logic [WIDTH-1:0]         y,
  output logic                     vld,
  output logic [$clog2(DEPTH):0]   fill
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  // Ring storage. The read is asynchronous so a tap change shows up in the
  // same cycle; contents are never reset, the vld gating hides stale words.
  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] wp_reg;
  logic [AW-1:0] wp_next;
  logic [AW:0]   fill_reg;
  logic [AW:0]   fill_next;

  logic [AW-1:0]    raddr;
  logic             vld_comb;
  logic [WIDTH-1:0] y_comb;

  // -------------------------------------------------------------------------
  // Write side
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (ce && !rst) begin
      mem[wp_reg] <= d;
    end
  end

  always_comb begin
    wp_next   = wp_reg;
    fill_next = fill_reg;
    if (ce) begin
      // Pointer arithmetic is naturally modulo DEPTH since DEPTH is 2**AW.
      wp_next = wp_reg + AW'(1);
    end
    if (clr) begin
      // A word written in the flush cycle is the first word of the new run.
      fill_next = {{AW{1'b0}}, ce};
    end else if (ce && (fill_reg != FULL)) begin
      fill_next = fill_reg + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_reg   <= '0;
      fill_reg <= '0;
    end else begin
      wp_reg   <= wp_next;
      fill_reg <= fill_next;
    end
  end

  // -------------------------------------------------------------------------
  // Read side
  // -------------------------------------------------------------------------
  // wp points at the next free slot, so the newest word sits at wp-1.
  assign raddr    = wp_reg - AW'(1) - a;
  assign vld_comb = (fill_reg > {1'b0, a});
  assign y_comb   = vld_comb ? mem[raddr] : '0;

  assign fill = fill_reg;

`ifdef VDELAY_BUF_OREG_EN
  logic [WIDTH-1:0] y_reg;
  logic             vld_reg;

  // Output stage runs every cycle, independent of ce, so a tap change with
  // the line frozen still appears one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_reg   <= '0;
      vld_reg <= 1'b0;
    end else begin
      y_reg   <= y_comb;
      vld_reg <= vld_comb;
    end
  end

  assign y   = y_reg;
  assign vld = vld_reg;
`else
  assign y   = y_comb;
  assign vld = vld_comb;
`endif

endmodule

// File: doc/vdelay_buf.md
VDELAY_BUF -- requirements
Module: vdelay_buf

Interface
REQ-001 Parameter WIDTH, default 36: data word width in bits, legal range 1..72.
REQ-002 Parameter DEPTH, default 32: maximum delay in words, power of two, legal range 2..256.
REQ-003 Local parameter AW = log2(DEPTH); not overridable.
REQ-004 The block SHALL use one clock, clk, and a synchronous, active-high reset, rst.
REQ-005 clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 d  input  WIDTH  input word.
REQ-008 a  input  AW  tap select; delay = a+1 enabled shifts.
REQ-009 ce  input  1  shift enable; writes d when high.
REQ-010 clr  input  1  synchronous flush of the fill count; RAM contents are not erased.
REQ-011 y  output  WIDTH  delayed word at tap a; zero when not valid.
REQ-012 vld  output  1  high when the selected tap holds a word written since the last reset or flush.
REQ-013 fill  output  AW+1  count of words written since the last reset or flush, saturating at DEPTH.

Function
REQ-014 Storage SHALL be a DEPTH x WIDTH circular buffer with write pointer wp (AW bits); ce=1 writes d at wp and increments wp modulo DEPTH.
REQ-015 Read address = (wp - 1 - a) mod DEPTH; a=0 selects the word written on the most recent enabled edge.
REQ-016 Without output register: y and vld SHALL be combinational from the current a, wp, fill and memory; a change on a is reflected in the same cycle.
REQ-017 fill: ce=1 and clr=0 -> fill+1, saturating at DEPTH; clr=1 -> fill = ce (1 if a word is written in the same cycle, else 0); otherwise hold.
REQ-018 vld = (fill > a).
REQ-019 y = mem[raddr] when vld=1; all zeros when vld=0.
REQ-020 ce=0 SHALL freeze wp, fill and memory; y may still change with a.
REQ-021 wp wrap from DEPTH-1 to 0 SHALL be seamless, with no gap or repeated word.
REQ-022 A tap change while fill=DEPTH SHALL give a valid word immediately, with no flush.
REQ-023 A tap change to a >= fill SHALL drop vld until enough words have been written.
REQ-024 clr SHALL NOT modify wp.

Reset
REQ-025 rst=1 at a rising edge SHALL set wp=0 and fill=0, giving vld=0 and y=0; it has priority over ce and clr.
REQ-026 Memory contents are not reset; vld gating hides them.
REQ-027 rst asserted mid-stream SHALL discard all history, and the first valid output for tap a SHALL appear after a+1 enabled writes.

Configuration
REQ-028 Macro VDELAY_BUF_OREG_EN, when defined: y and vld are registered on every clk edge (not gated by ce) from the REQ-018/019 values, adding exactly one clk of latency; rst clears both registers to 0.
REQ-029 Macro VDELAY_BUF_OREG_EN undefined: y and vld are combinational per REQ-016; fill is always combinational from its register in both builds.

Verification
REQ-030 Reset, then a=3 and ce=1 with d=1,2,3,...: vld rises in the cycle after the 4th write, y=1, and thereafter y=d-4 each cycle; fill=4 at the vld rise.
REQ-031 DEPTH=32, a=31, 40 continuous writes d=k: y=k-32 from write 32 onward, continuous across wp wrap; fill holds at 32.
REQ-032 fill=32, a is stepped 0->5->31 with ce=0: y changes in the same cycle (or next cycle with VDELAY_BUF_OREG_EN) to the words written 1, 6 and 32 shifts ago; vld stays 1.
REQ-033 clr=1 and ce=1 in the same cycle with a=0: fill=1, vld=1, y = the word written in that cycle; with a=2, vld=0 until 2 more writes.
REQ-034 rst pulsed mid-stream with ce=1: fill=0, vld=0, y=0 on the next cycle; no stale word is output for any a.
REQ-035 ce toggled 1,0,1,0 with a=1: y advances only on enabled edges; fill and wp hold while ce=0.
